// File: rtl/sc_point_pkg.sv
// Shared encodings and constants for the point register and its helpers.
package sc_point_pkg;

  // Point FSM states: the point is hidden in IDLE, movable in PLAY, and
  // GOAL marks the single cycle spent on the top row before respawning.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GOAL = 2'd2
  } state_t;

  // Column move codes; 00 and 11 both mean hold.
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Geometry and scoring limits.
  localparam int unsigned ROW_WIDTH   = 3;
  localparam int unsigned LEVEL_WIDTH = 4;
  localparam logic [ROW_WIDTH-1:0]   TOP_ROW   = 3'd7;
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = 4'd15;

endpackage : sc_point_pkg

// File: rtl/sc_levelcounter.sv
// Four-bit goal counter that sticks at LEVEL_MAX instead of wrapping.
module sc_levelcounter
  import sc_point_pkg::*;
(
  input  logic                   SC_LEVELCOUNTER_CLOCK_50,
  input  logic                   SC_LEVELCOUNTER_RESET_InHigh,
  input  logic                   SC_LEVELCOUNTER_clear_In,
  input  logic                   SC_LEVELCOUNTER_increment_In,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELCOUNTER_level_Out
);

  logic [LEVEL_WIDTH-1:0] levelReg;

  // Count completed goals; reset and clear both restart at zero.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50) begin
    if (SC_LEVELCOUNTER_RESET_InHigh || SC_LEVELCOUNTER_clear_In) begin
      levelReg <= '0;
    end else if (SC_LEVELCOUNTER_increment_In && (levelReg != LEVEL_MAX)) begin
      levelReg <= levelReg + 4'd1;
    end
  end

  assign SC_LEVELCOUNTER_level_Out = levelReg;

endmodule : sc_levelcounter

// File: rtl/sc_pointregister.sv
// Moving point on a DATAWIDTH_BUS x 8 matrix: one-hot column, 3-bit row,
// goal detection on the top row and a saturating level count.
module sc_pointregister
  import sc_point_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned START_COLUMN  = 3
) (
  input  logic                     SC_POINTREGISTER_CLOCK_50,
  input  logic                     SC_POINTREGISTER_RESET_InHigh,
  input  logic                     SC_POINTREGISTER_clear_InLow,
  input  logic                     SC_POINTREGISTER_load0_InLow,
  input  logic                     SC_POINTREGISTER_load1_InLow,
  input  logic [1:0]               SC_POINTREGISTER_shiftselection_In,
  output logic [DATAWIDTH_BUS-1:0] SC_POINTREGISTER_data_Out,
  output logic [ROW_WIDTH-1:0]     SC_POINTREGISTER_row_Out,
  output logic                     SC_POINTREGISTER_bottomsidecomparator_OutLow,
  output logic                     SC_POINTREGISTER_goal_Out,
  output logic [LEVEL_WIDTH-1:0]   SC_POINTREGISTER_level_Out
);

  localparam logic [DATAWIDTH_BUS-1:0] SPAWN_DATA =
    DATAWIDTH_BUS'(1) << START_COLUMN;

  state_t                   stateReg, stateNext;
  logic [ROW_WIDTH-1:0]     rowReg, rowNext;
  logic [DATAWIDTH_BUS-1:0] dataReg, dataNext;
  logic                     goalReg, goalNext;
  logic                     levelIncrement;
  logic                     levelClear;

  // Register the point state; reset forces the hidden IDLE point.
  always_ff @(posedge SC_POINTREGISTER_CLOCK_50) begin
    if (SC_POINTREGISTER_RESET_InHigh) begin
      stateReg <= IDLE;
      rowReg   <= '0;
      dataReg  <= '0;
      goalReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      rowReg   <= rowNext;
      dataReg  <= dataNext;
      goalReg  <= goalNext;
    end
  end

  // Apply the single highest-priority command: clear > up > down > shift.
  // NOTE: every signal gets a default before the branches so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext      = stateReg;
    rowNext        = rowReg;
    dataNext       = dataReg;
    goalNext       = 1'b0;
    levelIncrement = 1'b0;
    levelClear     = 1'b0;
    if (!SC_POINTREGISTER_clear_InLow) begin
      stateNext  = PLAY;
      rowNext    = '0;
      dataNext   = SPAWN_DATA;
      levelClear = 1'b1;
    end else begin
      unique case (stateReg)
        IDLE: begin
          // Hidden point ignores everything but clear.
        end
        PLAY: begin
          if (!SC_POINTREGISTER_load0_InLow) begin
            if (rowReg == TOP_ROW - 3'd1) begin
              stateNext      = GOAL;
              rowNext        = TOP_ROW;
              goalNext       = 1'b1;
              levelIncrement = 1'b1;
            end else begin
              rowNext = rowReg + 3'd1;
            end
          end else if (!SC_POINTREGISTER_load1_InLow) begin
            if (rowReg != '0) rowNext = rowReg - 3'd1;
          end else if (SC_POINTREGISTER_shiftselection_In == SHIFT_LEFT) begin
            if (!dataReg[DATAWIDTH_BUS-1]) dataNext = dataReg << 1;
          end else if (SC_POINTREGISTER_shiftselection_In == SHIFT_RIGHT) begin
            if (!dataReg[0]) dataNext = dataReg >> 1;
          end
        end
        GOAL: begin
          stateNext = PLAY;
          rowNext   = '0;
          dataNext  = SPAWN_DATA;
        end
        default: begin
          stateNext = IDLE;
          rowNext   = '0;
          dataNext  = '0;
        end
      endcase
    end
  end

  sc_levelcounter u_levelcounter (
    .SC_LEVELCOUNTER_CLOCK_50     (SC_POINTREGISTER_CLOCK_50),
    .SC_LEVELCOUNTER_RESET_InHigh (SC_POINTREGISTER_RESET_InHigh),
    .SC_LEVELCOUNTER_clear_In     (levelClear),
    .SC_LEVELCOUNTER_increment_In (levelIncrement),
    .SC_LEVELCOUNTER_level_Out    (SC_POINTREGISTER_level_Out)
  );

  // dataReg is zero whenever the point is hidden, so it drives the output directly.
  assign SC_POINTREGISTER_data_Out                    = dataReg;
  assign SC_POINTREGISTER_row_Out                     = rowReg;
  assign SC_POINTREGISTER_bottomsidecomparator_OutLow = (rowReg != '0);
  assign SC_POINTREGISTER_goal_Out                    = goalReg;

endmodule : sc_pointregister

// File: tb/tb_sc_pointregister.sv
// Directed bench for sc_pointregister with hand-computed expectations.
module tb_sc_pointregister;

  logic       clk;
  logic       rst;
  logic       clearN;
  logic       load0N;
  logic       load1N;
  logic [1:0] shiftSel;
  logic [7:0] dataOut;
  logic [2:0] rowOut;
  logic       bottomOutLow;
  logic       goalOut;
  logic [3:0] levelOut;

  int checks = 0;
  int errors = 0;

  sc_pointregister #(.DATAWIDTH_BUS(8), .START_COLUMN(3)) dut (
    .SC_POINTREGISTER_CLOCK_50                    (clk),
    .SC_POINTREGISTER_RESET_InHigh                (rst),
    .SC_POINTREGISTER_clear_InLow                 (clearN),
    .SC_POINTREGISTER_load0_InLow                 (load0N),
    .SC_POINTREGISTER_load1_InLow                 (load1N),
    .SC_POINTREGISTER_shiftselection_In           (shiftSel),
    .SC_POINTREGISTER_data_Out                    (dataOut),
    .SC_POINTREGISTER_row_Out                     (rowOut),
    .SC_POINTREGISTER_bottomsidecomparator_OutLow (bottomOutLow),
    .SC_POINTREGISTER_goal_Out                    (goalOut),
    .SC_POINTREGISTER_level_Out                   (levelOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clearN   = 1'b1;
    load0N   = 1'b1;
    load1N   = 1'b1;
    shiftSel = 2'b00;
  endtask

  // Six load0 pulses climb to row 6; the seventh enters GOAL.
  task automatic climb_to_goal();
    load0N = 1'b0;
    repeat (7) step();
    load0N = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    step();
    rst = 1'b0;
    check("rst_data",   dataOut,  8'h00);
    check("rst_row",    rowOut,   8'd0);
    check("rst_bottom", bottomOutLow, 1'b0);
    check("rst_goal",   goalOut,  1'b0);
    check("rst_level",  levelOut, 8'd0);

    // IDLE ignores moves.
    load0N = 1'b0; shiftSel = 2'b01;
    step();
    idle_inputs();
    check("idle_row",  rowOut,  8'd0);
    check("idle_data", dataOut, 8'h00);

    // Spawn.
    clearN = 1'b0;
    step();
    clearN = 1'b1;
    check("spawn_row",    rowOut,   8'd0);
    check("spawn_data",   dataOut,  8'b00001000);
    check("spawn_bottom", bottomOutLow, 1'b0);
    check("spawn_level",  levelOut, 8'd0);

    // Climb rows 1..6, then goal on the seventh pulse.
    load0N = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("climb_row%0d", i), rowOut, 8'(i));
      check($sformatf("climb_goal%0d", i), goalOut, 1'b0);
      check($sformatf("climb_bottom%0d", i), bottomOutLow, 1'b1);
    end
    step();
    check("goal_row",   rowOut,   8'd7);
    check("goal_pulse", goalOut,  1'b1);
    check("goal_level", levelOut, 8'd1);
    // load0 stays low through GOAL and must be ignored.
    step();
    load0N = 1'b1;
    check("respawn_row",   rowOut,   8'd0);
    check("respawn_data",  dataOut,  8'b00001000);
    check("respawn_goal",  goalOut,  1'b0);
    check("respawn_level", levelOut, 8'd1);

    // Down at the bottom holds; down from row 2 reaches row 1.
    load1N = 1'b0;
    step();
    load1N = 1'b1;
    check("down_floor_row",    rowOut, 8'd0);
    check("down_floor_bottom", bottomOutLow, 1'b0);
    load0N = 1'b0;
    repeat (2) step();
    load0N = 1'b1;
    check("up2_row", rowOut, 8'd2);
    load1N = 1'b0;
    step();
    load1N = 1'b1;
    check("down_row",    rowOut, 8'd1);
    check("down_bottom", bottomOutLow, 1'b1);

    // load0 beats load1 and shift.
    load0N = 1'b0; load1N = 1'b0; shiftSel = 2'b01;
    step();
    idle_inputs();
    check("prio_up_row",  rowOut,  8'd2);
    check("prio_up_data", dataOut, 8'b00001000);
    load0N = 1'b0;
    repeat (2) step();
    load0N = 1'b1;
    check("up4_row", rowOut, 8'd4);

    // clear beats load0 and shift at row 4.
    clearN = 1'b0; load0N = 1'b0; shiftSel = 2'b01;
    step();
    idle_inputs();
    check("prio_clear_row",   rowOut,   8'd0);
    check("prio_clear_level", levelOut, 8'd0);
    check("prio_clear_data",  dataOut,  8'b00001000);

    // Hold codes leave data alone.
    shiftSel = 2'b11;
    step();
    check("hold11_data", dataOut, 8'b00001000);

    // Left x5 saturates at the MSB.
    shiftSel = 2'b01;
    step();
    check("left1_data", dataOut, 8'b00010000);
    repeat (4) step();
    check("left5_data", dataOut, 8'b10000000);
    step();
    check("left_hold_data", dataOut, 8'b10000000);

    // Right x9 saturates at the LSB.
    shiftSel = 2'b10;
    step();
    check("right1_data", dataOut, 8'b01000000);
    repeat (8) step();
    shiftSel = 2'b00;
    check("right9_data", dataOut, 8'b00000001);
    check("right_row",   rowOut,  8'd0);

    // Fifteen goals bring level to 15.
    for (int g = 1; g <= 15; g++) begin
      climb_to_goal();
      step();
    end
    check("lvl15_level", levelOut, 8'd15);
    check("lvl15_row",   rowOut,   8'd0);

    // Sixteenth goal still pulses while level saturates.
    climb_to_goal();
    check("sat_goal",  goalOut,  1'b1);
    check("sat_level", levelOut, 8'd15);
    check("sat_row",   rowOut,   8'd7);

    // Reset during GOAL wins over the respawn.
    rst = 1'b1; load0N = 1'b0;
    step();
    rst = 1'b0;
    idle_inputs();
    check("goal_rst_data",   dataOut,  8'h00);
    check("goal_rst_row",    rowOut,   8'd0);
    check("goal_rst_goal",   goalOut,  1'b0);
    check("goal_rst_level",  levelOut, 8'd0);
    check("goal_rst_bottom", bottomOutLow, 1'b0);

    // Still IDLE afterwards: moves ignored.
    load0N = 1'b0;
    step();
    load0N = 1'b1;
    check("post_rst_row", rowOut, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sc_pointregister
